// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types and helpers for the rggen bridges.
// - rggen_direction : access direction on the register bus
// - rggen_status    : per-register response status
// - rggen_strobe_to_mask : expands a byte strobe (up to 8 lanes) into a
//   bitmask; callers truncate the 64-bit result to their data width.
package rggen_rtl_pkg;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

  localparam int RGGEN_MAX_STROBE_WIDTH = 8;

  function automatic logic [63:0] rggen_strobe_to_mask(input logic [7:0] strobe);
    logic [63:0] mask;
    mask = 64'h0;
    for (int i = 0; i < RGGEN_MAX_STROBE_WIDTH; i++) begin
      mask[i*8+:8] = {8{strobe[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_register_response_mux.sv
// AND-OR response collector for a set of register slave ports.
// Ports:
//   reg_select/reg_ready   : per-register address hit / completion
//   reg_read_data          : packed read data, register i at [i*DATA_WIDTH+:DATA_WIDTH]
//   reg_status             : packed 2-bit status per register
//   hit / done / multi_hit : any hit, a selected register is ready, more than one hit
//   read_data / status     : OR of the selected registers' data/status
// With more than one hit the OR-ed data is meaningless; the bridge discards it.
module rggen_register_response_mux #(
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1
) (
  input  logic [TOTAL_REGISTERS-1:0]            reg_select,
  input  logic [TOTAL_REGISTERS-1:0]            reg_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] reg_read_data,
  input  logic [TOTAL_REGISTERS*2-1:0]          reg_status,
  output logic                                  hit,
  output logic                                  done,
  output logic                                  multi_hit,
  output logic [DATA_WIDTH-1:0]                 read_data,
  output logic [1:0]                            status
);

  // Flags: clearing the lowest set bit leaves something only if two or more bits were set.
  always_comb begin
    hit       = |reg_select;
    done      = |(reg_select & reg_ready);
    multi_hit = |(reg_select & (reg_select - TOTAL_REGISTERS'(1)));
  end

  // AND-OR selection of read data and status.
  always_comb begin
    read_data = '0;
    status    = 2'b00;
    for (int i = 0; i < TOTAL_REGISTERS; i++) begin
      if (reg_select[i]) begin
        read_data = read_data | reg_read_data[i*DATA_WIDTH+:DATA_WIDTH];
        status    = status | reg_status[i*2+:2];
      end else begin
        read_data = read_data;
        status    = status;
      end
    end
  end

endmodule

// File: rtl/rggen_apb_bridge.sv
// APB4 slave to register-bus master bridge.
// Accepts one APB access at a time, broadcasts it to every register slave
// port and returns the selected register's response on PRDATA/PSLVERR.
// Ports:
//   clk, rst (sync, active-high)
//   APB   : psel, penable, paddr, pwrite, pwdata, pstrb -> pready, prdata, pslverr
//   Reg   : reg_request, reg_address, reg_direction, reg_write_data,
//           reg_write_strobe, reg_write_mask -> broadcast to all registers
//           reg_select, reg_ready, reg_read_data, reg_status <- per register
// A BUSY phase that sees neither completion nor a decode problem is ended
// after TIMEOUT cycles with a slave error (TIMEOUT=0 waits forever).
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT         = 255
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  psel,
  input  logic                                  penable,
  input  logic [ADDRESS_WIDTH-1:0]              paddr,
  input  logic                                  pwrite,
  input  logic [DATA_WIDTH-1:0]                 pwdata,
  input  logic [DATA_WIDTH/8-1:0]               pstrb,
  output logic                                  pready,
  output logic [DATA_WIDTH-1:0]                 prdata,
  output logic                                  pslverr,
  output logic                                  reg_request,
  output logic [ADDRESS_WIDTH-1:0]              reg_address,
  output rggen_direction                        reg_direction,
  output logic [DATA_WIDTH-1:0]                 reg_write_data,
  output logic [DATA_WIDTH/8-1:0]               reg_write_strobe,
  output logic [DATA_WIDTH-1:0]                 reg_write_mask,
  input  logic [TOTAL_REGISTERS-1:0]            reg_select,
  input  logic [TOTAL_REGISTERS-1:0]            reg_ready,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] reg_read_data,
  input  logic [TOTAL_REGISTERS*2-1:0]          reg_status
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int LSB_WIDTH    = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    ~((ADDRESS_WIDTH'(1) << LSB_WIDTH) - ADDRESS_WIDTH'(1));
  localparam int COUNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state_r;
  logic [COUNT_WIDTH-1:0]  count_r;
  logic [STROBE_WIDTH-1:0] strobe_s;
  logic                    hit_s;
  logic                    done_s;
  logic                    multi_hit_s;
  logic [DATA_WIDTH-1:0]   mux_data_s;
  logic [1:0]              mux_status_s;
  logic                    timeout_s;
  logic                    finish_s;
  logic [DATA_WIDTH-1:0]   result_data_s;
  rggen_status             result_status_s;

  rggen_register_response_mux #(
    .DATA_WIDTH      (DATA_WIDTH),
    .TOTAL_REGISTERS (TOTAL_REGISTERS)
  ) u_response_mux (
    .reg_select    (reg_select),
    .reg_ready     (reg_ready),
    .reg_read_data (reg_read_data),
    .reg_status    (reg_status),
    .hit           (hit_s),
    .done          (done_s),
    .multi_hit     (multi_hit_s),
    .read_data     (mux_data_s),
    .status        (mux_status_s)
  );

  // Reads carry no strobe on the register bus.
  always_comb begin
    if (pwrite) begin
      strobe_s = pstrb;
    end else begin
      strobe_s = '0;
    end
  end

  // BUSY-phase outcome, in priority order: multi-hit, no-hit, done, timeout.
  always_comb begin
    timeout_s = (TIMEOUT != 0) && (count_r == COUNT_LAST);
    finish_s  = multi_hit_s || !hit_s || done_s || timeout_s;
    if (multi_hit_s || !hit_s) begin
      result_data_s   = '0;
      result_status_s = RGGEN_DECODE_ERROR;
    end else if (done_s) begin
      result_data_s   = mux_data_s;
      result_status_s = rggen_status'(mux_status_s);
    end else begin
      result_data_s   = '0;
      result_status_s = RGGEN_SLAVE_ERROR;
    end
  end

  // Access FSM, broadcast latch, timeout counter and APB response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      count_r          <= '0;
      pready           <= 1'b0;
      prdata           <= '0;
      pslverr          <= 1'b0;
      reg_request      <= 1'b0;
      reg_address      <= '0;
      reg_direction    <= RGGEN_READ;
      reg_write_data   <= '0;
      reg_write_strobe <= '0;
      reg_write_mask   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          pready <= 1'b0;
          if (psel && !penable) begin
            state_r          <= BUSY;
            count_r          <= '0;
            reg_request      <= 1'b1;
            reg_address      <= paddr & ADDRESS_MASK;
            reg_direction    <= pwrite ? RGGEN_WRITE : RGGEN_READ;
            reg_write_data   <= pwdata;
            reg_write_strobe <= strobe_s;
            reg_write_mask   <= DATA_WIDTH'(rggen_strobe_to_mask(8'(strobe_s)));
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (finish_s) begin
            state_r     <= DONE;
            reg_request <= 1'b0;
            // pready is registered, so the APB access phase is checked on
            // the edge entering DONE; a withdrawn psel drops the response.
            pready      <= psel && penable;
            pslverr     <= result_status_s[1];
            prdata      <= (reg_direction == RGGEN_WRITE) ? '0 : result_data_s;
          end else begin
            state_r <= BUSY;
            count_r <= count_r + COUNT_WIDTH'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          pready  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          pready      <= 1'b0;
          reg_request <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Scoreboard bench for rggen_apb_bridge: stimulus pushes the expected
// response, a negedge monitor pops and compares whenever pready rises.
module tb_rggen_apb_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           psel = 1'b0;
  logic           penable = 1'b0;
  logic [AW-1:0]  paddr = '0;
  logic           pwrite = 1'b0;
  logic [DW-1:0]  pwdata = '0;
  logic [3:0]     pstrb = 4'h0;
  logic           pready;
  logic [DW-1:0]  prdata;
  logic           pslverr;
  logic           reg_request;
  logic [AW-1:0]  reg_address;
  rggen_direction reg_direction;
  logic [DW-1:0]  reg_write_data;
  logic [3:0]     reg_write_strobe;
  logic [DW-1:0]  reg_write_mask;
  logic [NR-1:0]  reg_select = '0;
  logic [NR-1:0]  reg_ready = '0;
  logic [NR*DW-1:0] reg_read_data = {32'h5555_3333, 32'hDEAD_BEEF, 32'h1234_5678, 32'hAAAA_0000};
  logic [NR*2-1:0]  reg_status = '0;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TOTAL_REGISTERS(NR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
    .prdata(prdata), .pslverr(pslverr), .reg_request(reg_request),
    .reg_address(reg_address), .reg_direction(reg_direction),
    .reg_write_data(reg_write_data), .reg_write_strobe(reg_write_strobe),
    .reg_write_mask(reg_write_mask), .reg_select(reg_select),
    .reg_ready(reg_ready), .reg_read_data(reg_read_data), .reg_status(reg_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    logic [15:0] addr;
    logic [31:0] mask;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic        dir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && pready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("prdata", prdata, mon_e.rdata);
        chk("pslverr", pslverr, mon_e.err);
        chk("pready_cycle", cyc, mon_e.cyc);
        chk("reg_address", reg_address, mon_e.addr);
        chk("reg_write_mask", reg_write_mask, mon_e.mask);
        chk("reg_write_strobe", reg_write_strobe, mon_e.strobe);
        chk("reg_write_data", reg_write_data, mon_e.wdata);
        chk("reg_direction", reg_direction, mon_e.dir);
        chk("reg_request_done", reg_request, 1'b0);
      end
    end
  end

  task automatic apb(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [3:0] sel, input logic [3:0] rdy,
                     input int wait_n, input logic [7:0] status, input logic [31:0] exp_rdata,
                     input logic exp_err, input int exp_lat, input logic [15:0] exp_addr,
                     input logic [31:0] exp_mask);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    e = '{rdata: exp_rdata, err: exp_err, cyc: cyc + exp_lat, addr: exp_addr, mask: exp_mask,
          strobe: (wr ? strb : 4'h0), wdata: wdata, dir: wr};
    sb.push_back(e);
    @(posedge clk); #1;
    penable = 1'b1; reg_select = sel; reg_status = status;
    for (int k = 0; k < 20 && !seen; k++) begin
      reg_ready = (k >= wait_n) ? rdy : 4'h0;
      @(negedge clk);
      if (k == 0) chk("reg_request_busy", reg_request, 1'b1);
      if (pready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL pready_wait: got no pready expected one within 20 cycles (addr %0h)", addr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; reg_select = '0; reg_ready = '0; reg_status = '0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pready", pready, 1'b0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", pslverr, 1'b0);
    chk("rst_reg_request", reg_request, 1'b0);
    chk("rst_reg_address", reg_address, 16'h0);
    chk("rst_reg_direction", reg_direction, RGGEN_READ);
    chk("rst_reg_write_data", reg_write_data, 32'h0);
    chk("rst_reg_write_strobe", reg_write_strobe, 4'h0);
    chk("rst_reg_write_mask", reg_write_mask, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write 0xA5, one byte lane, reg1 ready immediately
    apb(16'h0004, 1'b1, 32'h0000_00A5, 4'b0001, 4'b0010, 4'b0010, 0, 8'h00,
        32'h0, 1'b0, 2, 16'h0004, 32'h0000_00FF);
    // Read reg2 after three wait cycles
    apb(16'h0008, 1'b0, 32'h0, 4'hF, 4'b0100, 4'b0100, 3, 8'h00,
        32'hDEAD_BEEF, 1'b0, 5, 16'h0008, 32'h0);
    // No register decodes the address
    apb(16'h0100, 1'b0, 32'h0, 4'hF, 4'b0000, 4'b0000, 0, 8'h00,
        32'h0, 1'b1, 2, 16'h0100, 32'h0);
    // reg0 selected but never ready: timeout
    apb(16'h0000, 1'b0, 32'h0, 4'hF, 4'b0001, 4'b0000, 0, 8'h00,
        32'h0, 1'b1, 5, 16'h0000, 32'h0);
    // reg1 and reg3 both hit
    apb(16'h000C, 1'b0, 32'h0, 4'hF, 4'b1010, 4'b1010, 0, 8'h00,
        32'h0, 1'b1, 2, 16'h000C, 32'h0);
    // reg1 alone answers SLAVE_ERROR: data still returned
    apb(16'h0004, 1'b0, 32'h0, 4'hF, 4'b0010, 4'b0010, 0, 8'b0000_1000,
        32'h1234_5678, 1'b1, 2, 16'h0004, 32'h0);
    // Unaligned write, upper two lanes
    apb(16'h0007, 1'b1, 32'hCAFE_F00D, 4'b1100, 4'b0010, 4'b0010, 0, 8'h00,
        32'h0, 1'b0, 2, 16'h0004, 32'hFFFF_0000);
    // Full-width write with one wait cycle
    apb(16'h0000, 1'b1, 32'h0BAD_F00D, 4'b1111, 4'b0001, 4'b0001, 1, 8'h00,
        32'h0, 1'b0, 3, 16'h0000, 32'hFFFF_FFFF);

    // psel withdrawn during BUSY: access finishes, no pready
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0008; pwrite = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0; reg_select = 4'b0100; reg_ready = 4'b0100;
    @(negedge clk);
    chk("drop_request_busy", reg_request, 1'b1);
    @(posedge clk); #1;
    reg_select = '0; reg_ready = '0;
    @(negedge clk);
    chk("drop_request_done", reg_request, 1'b0);
    chk("drop_pready", pready, 1'b0);

    // Reset while waiting on a register
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 16'h0008; pwrite = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1; reg_select = 4'b0001; reg_ready = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0; reg_select = '0;
    @(negedge clk);
    chk("rstbusy_reg_request", reg_request, 1'b0);
    chk("rstbusy_pready", pready, 1'b0);
    chk("rstbusy_reg_address", reg_address, 16'h0);
    // Next access completes normally
    apb(16'h0000, 1'b0, 32'h0, 4'hF, 4'b0001, 4'b0001, 1, 8'h00,
        32'hAAAA_0000, 1'b0, 3, 16'h0000, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
